ob_match_ctrl: RTL and testbench

- Controller on the far side of the bid and ask order-table head and reject interfaces.
- Each cycle it compares the bid head against the ask head. When they cross, it emits a trade on a valid/ready stream and writes the result back to the tables: it pops exhausted heads and updates a partially filled head with its residual quantity.
- It also drains both tables' reject slots onto one reject stream with round-robin arbitration.
- It sits between the two `ob_table` instances (bid: `is_ask=0`, ask: `is_ask=1`) and the egress formatter.

---
 rtl/ob_match_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_ob_match_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ob_match_ctrl.sv
// rtl/ob_match_ctrl.sv - order-book match controller: head cross detect, trade stream, reject drain
// Optional trade statistics counter is built when OB_MATCH_CTRL_STATS_EN is defined.
package bcd_pkg;
  // six BCD digits: four integer, two fractional (100.00 = 24'h010000)
  typedef logic [23:0] price_t;
endpackage

package ob_pkg;
  typedef logic [15:0] uid_t;
  typedef logic [15:0] quantity_t;
  typedef struct packed {
    uid_t            uid;
    bcd_pkg::price_t price;
    quantity_t       quantity;
  } table_t;
endpackage

module ob_match_ctrl
  import ob_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bid_head_vld_r,
  input  logic                 ask_head_vld_r,
  input  logic                 bid_head_did_update_r,
  input  logic                 ask_head_did_update_r,
  input  table_t               bid_head_r,
  input  table_t               ask_head_r,
  output logic                 bid_head_pop,
  output logic                 ask_head_pop,
  output logic                 bid_head_upt,
  output logic                 ask_head_upt,
  output table_t               bid_head_upt_tbl,
  output table_t               ask_head_upt_tbl,
  input  logic                 bid_reject_vld_r,
  input  logic                 ask_reject_vld_r,
  input  table_t               bid_reject_r,
  input  table_t               ask_reject_r,
  output logic                 bid_reject_pop,
  output logic                 ask_reject_pop,
  input  logic                 match_en,
  output logic                 match_busy,
  output logic                 trade_vld_r,
  input  logic                 trade_rdy,
  output uid_t                 trade_bid_uid_r,
  output uid_t                 trade_ask_uid_r,
  output bcd_pkg::price_t      trade_price_r,
  output quantity_t            trade_qty_r,
  output logic                 rej_vld_r,
  input  logic                 rej_rdy,
  output logic                 rej_is_ask_r,
  output table_t               rej_r,
  output logic [CNT_W-1:0]     trade_cnt_r
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_SETTLE} state_t;

  state_t    r_state;
  state_t    w_state_nxt;
  table_t    r_bid_ent;
  table_t    r_ask_ent;
  logic      w_cross;
  logic      w_hs;
  quantity_t w_min_qty;
  logic      w_unused;

  assign w_unused   = &{1'b0, bid_head_did_update_r, ask_head_did_update_r};
  assign w_cross    = match_en & bid_head_vld_r & ask_head_vld_r &
                      (bid_head_r.price >= ask_head_r.price);
  assign w_min_qty  = (bid_head_r.quantity < ask_head_r.quantity) ?
                      bid_head_r.quantity : ask_head_r.quantity;
  assign match_busy = (r_state != S_IDLE) | w_cross;

  // Table writes are gated by rst so a reset landing on the handshake drops the trade cleanly.
  always_comb begin
    w_state_nxt      = r_state;
    w_hs             = 1'b0;
    bid_head_pop     = 1'b0;
    ask_head_pop     = 1'b0;
    bid_head_upt     = 1'b0;
    ask_head_upt     = 1'b0;
    bid_head_upt_tbl = r_bid_ent;
    ask_head_upt_tbl = r_ask_ent;
    bid_head_upt_tbl.quantity = r_bid_ent.quantity - trade_qty_r;
    ask_head_upt_tbl.quantity = r_ask_ent.quantity - trade_qty_r;
    case (r_state)
      S_IDLE: begin
        if (w_cross) w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        if (trade_rdy) begin
          w_state_nxt = S_SETTLE;
          w_hs        = ~rst;
          if (r_bid_ent.quantity == r_ask_ent.quantity) begin
            bid_head_pop = ~rst;
            ask_head_pop = ~rst;
          end else if (r_bid_ent.quantity > r_ask_ent.quantity) begin
            ask_head_pop = ~rst;
            bid_head_upt = ~rst;
          end else begin
            bid_head_pop = ~rst;
            ask_head_upt = ~rst;
          end
        end
      end
      S_SETTLE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      trade_vld_r     <= 1'b0;
      trade_bid_uid_r <= '0;
      trade_ask_uid_r <= '0;
      trade_price_r   <= '0;
      trade_qty_r     <= '0;
      r_bid_ent       <= '0;
      r_ask_ent       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_cross) begin
        trade_vld_r     <= 1'b1;
        trade_bid_uid_r <= bid_head_r.uid;
        trade_ask_uid_r <= ask_head_r.uid;
        trade_price_r   <= ask_head_r.price;
        trade_qty_r     <= w_min_qty;
        r_bid_ent       <= bid_head_r;
        r_ask_ent       <= ask_head_r;
      end else if (w_hs) begin
        trade_vld_r <= 1'b0;
      end
    end
  end

  logic r_rr_last_ask;
  logic r_ask_rej_popped;
  logic r_bid_rej_popped;
  logic w_rej_free;
  logic w_ask_elig;
  logic w_bid_elig;
  logic w_gnt_ask;
  logic w_gnt_bid;

  // A slot popped last cycle still shows its stale entry while it refills.
  assign w_rej_free     = ~rej_vld_r | rej_rdy;
  assign w_ask_elig     = ask_reject_vld_r & ~r_ask_rej_popped;
  assign w_bid_elig     = bid_reject_vld_r & ~r_bid_rej_popped;
  assign w_gnt_ask      = ~rst & w_rej_free & w_ask_elig & (~w_bid_elig | ~r_rr_last_ask);
  assign w_gnt_bid      = ~rst & w_rej_free & w_bid_elig & ~w_gnt_ask;
  assign ask_reject_pop = w_gnt_ask;
  assign bid_reject_pop = w_gnt_bid;

  always_ff @(posedge clk) begin
    if (rst) begin
      rej_vld_r        <= 1'b0;
      rej_is_ask_r     <= 1'b0;
      rej_r            <= '0;
      r_rr_last_ask    <= 1'b0;
      r_ask_rej_popped <= 1'b0;
      r_bid_rej_popped <= 1'b0;
    end else begin
      r_ask_rej_popped <= w_gnt_ask;
      r_bid_rej_popped <= w_gnt_bid;
      if (w_gnt_ask | w_gnt_bid) begin
        rej_vld_r     <= 1'b1;
        rej_r         <= w_gnt_ask ? ask_reject_r : bid_reject_r;
        rej_is_ask_r  <= w_gnt_ask;
        r_rr_last_ask <= w_gnt_ask;
      end else if (rej_rdy) begin
        rej_vld_r <= 1'b0;
      end
    end
  end

`ifdef OB_MATCH_CTRL_STATS_EN
  logic [CNT_W-1:0] r_trade_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_trade_cnt <= '0;
    end else if (w_hs && (r_trade_cnt != {CNT_W{1'b1}})) begin
      r_trade_cnt <= r_trade_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign trade_cnt_r = r_trade_cnt;
`else
  assign trade_cnt_r = '0;
`endif

endmodule

// File: tb/tb_ob_match_ctrl.sv
// tb/tb_ob_match_ctrl.sv - self-checking bench for ob_match_ctrl (vector table, corner sequences, random books)
module tb_ob_match_ctrl;
  import ob_pkg::*;

  localparam int CNT_W = 32;
`ifdef OB_MATCH_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic bid_head_vld_r, ask_head_vld_r, bid_head_did_update_r, ask_head_did_update_r;
  table_t bid_head_r, ask_head_r;
  logic bid_head_pop, ask_head_pop, bid_head_upt, ask_head_upt;
  table_t bid_head_upt_tbl, ask_head_upt_tbl;
  logic bid_reject_vld_r, ask_reject_vld_r;
  table_t bid_reject_r, ask_reject_r;
  logic bid_reject_pop, ask_reject_pop;
  logic match_en, match_busy, trade_vld_r, trade_rdy;
  uid_t trade_bid_uid_r, trade_ask_uid_r;
  bcd_pkg::price_t trade_price_r;
  quantity_t trade_qty_r;
  logic rej_vld_r, rej_rdy, rej_is_ask_r;
  table_t rej_r;
  logic [CNT_W-1:0] trade_cnt_r;

  int n_cmp = 0;
  int n_err = 0;

  ob_match_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .bid_head_vld_r(bid_head_vld_r), .ask_head_vld_r(ask_head_vld_r),
    .bid_head_did_update_r(bid_head_did_update_r), .ask_head_did_update_r(ask_head_did_update_r),
    .bid_head_r(bid_head_r), .ask_head_r(ask_head_r),
    .bid_head_pop(bid_head_pop), .ask_head_pop(ask_head_pop),
    .bid_head_upt(bid_head_upt), .ask_head_upt(ask_head_upt),
    .bid_head_upt_tbl(bid_head_upt_tbl), .ask_head_upt_tbl(ask_head_upt_tbl),
    .bid_reject_vld_r(bid_reject_vld_r), .ask_reject_vld_r(ask_reject_vld_r),
    .bid_reject_r(bid_reject_r), .ask_reject_r(ask_reject_r),
    .bid_reject_pop(bid_reject_pop), .ask_reject_pop(ask_reject_pop),
    .match_en(match_en), .match_busy(match_busy),
    .trade_vld_r(trade_vld_r), .trade_rdy(trade_rdy),
    .trade_bid_uid_r(trade_bid_uid_r), .trade_ask_uid_r(trade_ask_uid_r),
    .trade_price_r(trade_price_r), .trade_qty_r(trade_qty_r),
    .rej_vld_r(rej_vld_r), .rej_rdy(rej_rdy), .rej_is_ask_r(rej_is_ask_r), .rej_r(rej_r),
    .trade_cnt_r(trade_cnt_r)
  );

  typedef struct {
    bcd_pkg::price_t bp; quantity_t bq;
    bcd_pkg::price_t ap; quantity_t aq;
    logic bv; logic av; logic en;
    logic x; quantity_t q; logic [3:0] ops; quantity_t res;
  } vec_t;

  typedef struct packed {
    uid_t b; uid_t a; bcd_pkg::price_t p; quantity_t q;
  } trade_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic table_t mk(input uid_t u, input bcd_pkg::price_t p, input quantity_t q);
    table_t t;
    t.uid = u; t.price = p; t.quantity = q;
    return t;
  endfunction

  function automatic logic [127:0] exp_cnt(input int n);
    return STATS ? 128'(n) : 128'd0;
  endfunction

  function automatic bcd_pkg::price_t pick_price(input int k);
    case (k)
      0: return 24'h009900;
      1: return 24'h009925;
      2: return 24'h009950;
      3: return 24'h009975;
      4: return 24'h010000;
      default: return 24'h010025;
    endcase
  endfunction

  task automatic idle_inputs();
    bid_head_vld_r = 1'b0; ask_head_vld_r = 1'b0;
    bid_head_did_update_r = 1'b0; ask_head_did_update_r = 1'b0;
    bid_head_r = '0; ask_head_r = '0;
    bid_reject_vld_r = 1'b0; ask_reject_vld_r = 1'b0;
    bid_reject_r = '0; ask_reject_r = '0;
    match_en = 1'b0; trade_rdy = 1'b0; rej_rdy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_random();
    table_t bq[$], aq[$], brj[$], arj[$], mb[$], ma[$], erb[$], era[$];
    trade_t et[$];
    trade_t t;
    table_t tb_e, ta_e, pb_val, pa_val;
    int nb, na, ntr, tail, cyc;
    logic pb_pop, pa_pop, pb_upt, pa_upt, pbr_pop, par_pop, hs;
    quantity_t q;

    nb = $urandom_range(2, 8);
    na = $urandom_range(2, 8);
    for (int i = 0; i < nb; i++)
      bq.push_back(mk(uid_t'(16'h1000 + i), pick_price($urandom_range(0, 5)), quantity_t'($urandom_range(1, 20))));
    for (int i = 0; i < na; i++)
      aq.push_back(mk(uid_t'(16'h2000 + i), pick_price($urandom_range(0, 5)), quantity_t'($urandom_range(1, 20))));
    for (int i = 0; i < int'($urandom_range(0, 5)); i++)
      brj.push_back(mk(uid_t'(16'h3000 + i), pick_price(i), quantity_t'(i + 1)));
    for (int i = 0; i < int'($urandom_range(0, 5)); i++)
      arj.push_back(mk(uid_t'(16'h4000 + i), pick_price(i), quantity_t'(i + 7)));
    erb = brj;
    era = arj;

    // price-time matching of the two books: ask price, min quantity, exhausted heads leave
    mb = bq;
    ma = aq;
    while (mb.size() > 0 && ma.size() > 0 && mb[0].price >= ma[0].price) begin
      tb_e = mb[0];
      ta_e = ma[0];
      q = (tb_e.quantity < ta_e.quantity) ? tb_e.quantity : ta_e.quantity;
      t.b = tb_e.uid; t.a = ta_e.uid; t.p = ta_e.price; t.q = q;
      et.push_back(t);
      tb_e.quantity = tb_e.quantity - q;
      ta_e.quantity = ta_e.quantity - q;
      mb[0] = tb_e;
      ma[0] = ta_e;
      if (tb_e.quantity == 0) void'(mb.pop_front());
      if (ta_e.quantity == 0) void'(ma.pop_front());
    end
    ntr = et.size();

    do_reset();
    pb_pop = 0; pa_pop = 0; pb_upt = 0; pa_upt = 0; pbr_pop = 0; par_pop = 0;
    pb_val = '0; pa_val = '0;
    tail = 0;
    for (cyc = 0; cyc < 3000 && tail < 4; cyc++) begin
      @(negedge clk);
      bid_head_did_update_r = pb_pop | pb_upt;
      ask_head_did_update_r = pa_pop | pa_upt;
      if (pb_pop && bq.size() > 0) void'(bq.pop_front());
      else if (pb_upt && bq.size() > 0) bq[0] = pb_val;
      if (pa_pop && aq.size() > 0) void'(aq.pop_front());
      else if (pa_upt && aq.size() > 0) aq[0] = pa_val;
      if (pbr_pop && brj.size() > 0) void'(brj.pop_front());
      if (par_pop && arj.size() > 0) void'(arj.pop_front());
      bid_head_vld_r = (bq.size() > 0);
      ask_head_vld_r = (aq.size() > 0);
      bid_head_r = '0; ask_head_r = '0; bid_reject_r = '0; ask_reject_r = '0;
      if (bq.size() > 0) bid_head_r = bq[0];
      if (aq.size() > 0) ask_head_r = aq[0];
      bid_reject_vld_r = (brj.size() > 0);
      ask_reject_vld_r = (arj.size() > 0);
      if (brj.size() > 0) bid_reject_r = brj[0];
      if (arj.size() > 0) ask_reject_r = arj[0];
      match_en  = ($urandom_range(0, 3) != 0);
      trade_rdy = ($urandom_range(0, 9) < 7);
      rej_rdy   = ($urandom_range(0, 9) < 6);
      #1;
      hs = trade_vld_r & trade_rdy;
      chk("rnd_head_op_outside_hs", {bid_head_pop, ask_head_pop, bid_head_upt, ask_head_upt} & {4{~hs}}, 0);
      chk("rnd_pop_with_upt", {bid_head_pop & bid_head_upt, ask_head_pop & ask_head_upt}, 0);
      chk("rnd_rej_pop_no_vld", {bid_reject_pop & ~bid_reject_vld_r, ask_reject_pop & ~ask_reject_vld_r}, 0);
      if (hs) begin
        if (et.size() == 0) begin
          chk("rnd_unexpected_trade", 1, 0);
        end else begin
          t = et.pop_front();
          chk("rnd_trade", {trade_bid_uid_r, trade_ask_uid_r, trade_price_r, trade_qty_r}, t);
        end
      end
      if (rej_vld_r && rej_rdy) begin
        if (rej_is_ask_r) begin
          if (era.size() == 0) chk("rnd_unexpected_ask_rej", 1, 0);
          else chk("rnd_ask_rej", rej_r, era.pop_front());
        end else begin
          if (erb.size() == 0) chk("rnd_unexpected_bid_rej", 1, 0);
          else chk("rnd_bid_rej", rej_r, erb.pop_front());
        end
      end
      pb_pop = bid_head_pop; pa_pop = ask_head_pop;
      pb_upt = bid_head_upt; pa_upt = ask_head_upt;
      pb_val = bid_head_upt_tbl; pa_val = ask_head_upt_tbl;
      pbr_pop = bid_reject_pop; par_pop = ask_reject_pop;
      if (et.size() == 0 && era.size() == 0 && erb.size() == 0) tail++;
    end
    chk("rnd_drained_in_budget", 128'(et.size() + era.size() + erb.size()), 0);
    chk("rnd_book_sizes", {bq.size(), aq.size()}, {mb.size(), ma.size()});
    for (int i = 0; i < mb.size() && i < bq.size(); i++) chk("rnd_bid_book", bq[i], mb[i]);
    for (int i = 0; i < ma.size() && i < aq.size(); i++) chk("rnd_ask_book", aq[i], ma[i]);
    chk("rnd_trade_cnt", trade_cnt_r, exp_cnt(ntr));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    table_t be, ae;
    rst = 1'b1;
    idle_inputs();

    vt[0] = '{24'h010000, 16'd5,     24'h009950, 16'd5,     1, 1, 1, 1, 16'd5, 4'b1100, 16'd0};
    vt[1] = '{24'h010000, 16'd8,     24'h009950, 16'd3,     1, 1, 1, 1, 16'd3, 4'b0110, 16'd5};
    vt[2] = '{24'h009950, 16'd2,     24'h009950, 16'd7,     1, 1, 1, 1, 16'd2, 4'b1001, 16'd5};
    vt[3] = '{24'h009900, 16'd5,     24'h009950, 16'd5,     1, 1, 1, 0, 16'd0, 4'b0000, 16'd0};
    vt[4] = '{24'h010000, 16'd5,     24'h009950, 16'd5,     0, 1, 1, 0, 16'd0, 4'b0000, 16'd0};
    vt[5] = '{24'h010000, 16'd5,     24'h009950, 16'd5,     1, 0, 1, 0, 16'd0, 4'b0000, 16'd0};
    vt[6] = '{24'h010000, 16'd5,     24'h009950, 16'd5,     1, 1, 0, 0, 16'd0, 4'b0000, 16'd0};
    vt[7] = '{24'h016000, 16'd65535, 24'h015999, 16'd1,     1, 1, 1, 1, 16'd1, 4'b0110, 16'd65534};
    vt[8] = '{24'h000001, 16'd1,     24'h000000, 16'd65535, 1, 1, 1, 1, 16'd1, 4'b1001, 16'd65534};

    do_reset();
    #1;
    chk("rst_trade_vld", trade_vld_r, 0);
    chk("rst_rej_vld", rej_vld_r, 0);
    chk("rst_head_ops", {bid_head_pop, ask_head_pop, bid_head_upt, ask_head_upt}, 0);
    chk("rst_rej_pops", {bid_reject_pop, ask_reject_pop}, 0);
    chk("rst_trade_data", {trade_bid_uid_r, trade_ask_uid_r, trade_price_r, trade_qty_r}, 0);
    chk("rst_rej_data", {rej_is_ask_r, rej_r}, 0);
    chk("rst_cnt", trade_cnt_r, 0);
    chk("rst_busy", match_busy, 0);

    for (int i = 0; i < 9; i++) begin
      do_reset();
      bid_head_r = mk(uid_t'(16'h1000 + i), vt[i].bp, vt[i].bq);
      ask_head_r = mk(uid_t'(16'h2000 + i), vt[i].ap, vt[i].aq);
      bid_head_vld_r = vt[i].bv;
      ask_head_vld_r = vt[i].av;
      match_en = vt[i].en;
      trade_rdy = 1'b1;
      #1;
      chk("vec_busy", match_busy, vt[i].x);
      chk("vec_no_ops_idle", {bid_head_pop, ask_head_pop, bid_head_upt, ask_head_upt}, 0);
      @(negedge clk); #1;
      chk("vec_trade_vld", trade_vld_r, vt[i].x);
      if (vt[i].x) begin
        chk("vec_trade", {trade_bid_uid_r, trade_ask_uid_r, trade_price_r, trade_qty_r},
            {uid_t'(16'h1000 + i), uid_t'(16'h2000 + i), vt[i].ap, vt[i].q});
        chk("vec_ops", {bid_head_pop, ask_head_pop, bid_head_upt, ask_head_upt}, vt[i].ops);
        if (vt[i].ops[1]) chk("vec_bid_upt_tbl", bid_head_upt_tbl, mk(uid_t'(16'h1000 + i), vt[i].bp, vt[i].res));
        if (vt[i].ops[0]) chk("vec_ask_upt_tbl", ask_head_upt_tbl, mk(uid_t'(16'h2000 + i), vt[i].ap, vt[i].res));
      end else begin
        chk("vec_idle_busy", match_busy, 0);
        chk("vec_idle_ops", {bid_head_pop, ask_head_pop, bid_head_upt, ask_head_upt}, 0);
      end
      @(negedge clk); #1;
      chk("vec_settle_vld", trade_vld_r, 0);
      chk("vec_settle_ops", {bid_head_pop, ask_head_pop, bid_head_upt, ask_head_upt}, 0);
      chk("vec_cnt", trade_cnt_r, exp_cnt(vt[i].x ? 1 : 0));
    end

    // backpressure in EMIT, then back-to-back match on the partially filled bid
    do_reset();
    bid_head_r = mk(16'h1100, 24'h010000, 16'd8);
    ask_head_r = mk(16'h2100, 24'h009950, 16'd3);
    bid_head_vld_r = 1; ask_head_vld_r = 1; match_en = 1; trade_rdy = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk("stall_vld", trade_vld_r, 1);
      chk("stall_fields", {trade_bid_uid_r, trade_ask_uid_r, trade_price_r, trade_qty_r},
          {16'h1100, 16'h2100, 24'h009950, 16'd3});
      chk("stall_busy", match_busy, 1);
      chk("stall_no_ops", {bid_head_pop, ask_head_pop, bid_head_upt, ask_head_upt}, 0);
    end
    @(negedge clk);
    trade_rdy = 1;
    #1;
    chk("stall_hs_ops", {bid_head_pop, ask_head_pop, bid_head_upt, ask_head_upt}, 4'b0110);
    chk("stall_hs_upt", bid_head_upt_tbl, mk(16'h1100, 24'h010000, 16'd5));
    @(negedge clk);
    bid_head_r = mk(16'h1100, 24'h010000, 16'd5);
    ask_head_r = mk(16'h2101, 24'h009950, 16'd2);
    #1;
    chk("settle_vld", trade_vld_r, 0);
    chk("settle_busy", match_busy, 1);
    chk("settle_ops", {bid_head_pop, ask_head_pop, bid_head_upt, ask_head_upt}, 0);
    @(negedge clk); #1;
    chk("rematch_detect_vld", trade_vld_r, 0);
    @(negedge clk); #1;
    chk("rematch_vld", trade_vld_r, 1);
    chk("rematch_fields", {trade_bid_uid_r, trade_ask_uid_r, trade_qty_r}, {16'h1100, 16'h2101, 16'd2});
    chk("rematch_ops", {bid_head_pop, ask_head_pop, bid_head_upt, ask_head_upt}, 4'b0110);
    chk("rematch_upt", bid_head_upt_tbl, mk(16'h1100, 24'h010000, 16'd3));
    @(negedge clk); #1;
    chk("rematch_cnt", trade_cnt_r, exp_cnt(2));

    // reset arriving while a trade is held in EMIT
    do_reset();
    bid_head_r = mk(16'h1200, 24'h010000, 16'd4);
    ask_head_r = mk(16'h2200, 24'h010000, 16'd4);
    bid_head_vld_r = 1; ask_head_vld_r = 1; match_en = 1; trade_rdy = 0;
    @(negedge clk); #1;
    chk("rstemit_vld", trade_vld_r, 1);
    @(negedge clk);
    rst = 1; trade_rdy = 1;
    #1;
    chk("rstemit_no_ops", {bid_head_pop, ask_head_pop, bid_head_upt, ask_head_upt}, 0);
    @(negedge clk);
    rst = 0; bid_head_vld_r = 0; ask_head_vld_r = 0; trade_rdy = 0;
    #1;
    chk("rstemit_after", {trade_vld_r, rej_vld_r, match_busy, bid_head_pop, ask_head_pop, bid_head_upt, ask_head_upt}, 0);
    chk("rstemit_data", {trade_bid_uid_r, trade_ask_uid_r, trade_price_r, trade_qty_r}, 0);
    chk("rstemit_cnt", trade_cnt_r, 0);

    // reject round-robin with both slots persistently valid
    do_reset();
    be = mk(16'h3300, 24'h009900, 16'd1);
    ae = mk(16'h4400, 24'h010100, 16'd2);
    bid_reject_r = be; ask_reject_r = ae;
    bid_reject_vld_r = 1; ask_reject_vld_r = 1; rej_rdy = 1;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("rr_pops", {bid_reject_pop, ask_reject_pop}, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k == 0) begin
        chk("rr_latency", rej_vld_r, 0);
      end else begin
        chk("rr_vld", rej_vld_r, 1);
        chk("rr_is_ask", rej_is_ask_r, (k % 2 == 1));
        chk("rr_entry", rej_r, (k % 2 == 1) ? ae : be);
      end
      if (k < 7) begin
        @(negedge clk); #1;
      end
    end
    @(negedge clk);
    rej_rdy = 0;
    #1;
    chk("rr_hold_vld", {rej_vld_r, rej_is_ask_r}, 2'b10);
    chk("rr_hold_no_pop", {bid_reject_pop, ask_reject_pop}, 0);
    @(negedge clk); #1;
    chk("rr_hold2", {rej_vld_r, rej_is_ask_r, rej_r}, {2'b10, be});
    chk("rr_hold2_no_pop", {bid_reject_pop, ask_reject_pop}, 0);
    @(negedge clk);
    rej_rdy = 1;
    #1;
    chk("rr_resume", {bid_reject_pop, ask_reject_pop}, 2'b01);

    for (int r = 0; r < 4; r++) run_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
